// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch/commit sequencer and its next-PC helper.
package pc_fetch_sequencer_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] RESET_VECTOR_DEFAULT = 64'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  function automatic logic is_aligned(input logic [PC_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: sequential PC+4 or PC-relative branch target, with alignment flag.
module next_pc_calc
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] current_pc,
  input  logic [PC_W-1:0] sign_ext_imm,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic            uncond_branch,
  output logic [PC_W-1:0] next_pc,
  output logic            misaligned
);

  logic taken_s;

  // Select the commit target; the add wraps modulo 2^64 by construction.
  always_comb begin
    taken_s = uncond_branch | (branch & alu_zero);
    if (taken_s) begin
      next_pc = current_pc + sign_ext_imm;
    end else begin
      next_pc = current_pc + PC_W'(INSTR_BYTES);
    end
    misaligned = !is_aligned(next_pc);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/commit sequencer: owns the PC, fetches over req/gnt/resp, hands the word to the
// datapath and commits the next PC when execution completes.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int              CNT_W        = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic               ImemGnt,
  input  logic               ImemRespValid,
  input  logic [INSTR_W-1:0] ImemRdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  input  logic               ExecDone,
  input  logic               Branch,
  input  logic               ALUZero,
  input  logic               Uncondbranch,
  input  logic [PC_W-1:0]    SignExtImm64,
  input  logic               Halt,
  output logic [PC_W-1:0]    CurrentPC,
  output logic               Halted,
  output logic               Fault,
  output logic [CNT_W-1:0]   RetireCount
);

  state_e             state_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic [CNT_W-1:0]   retire_r;
  logic               req_r;
  logic               valid_r;
  logic               halted_r;
  logic               fault_r;
  logic [PC_W-1:0]    next_pc_s;
  logic               misaligned_s;

  next_pc_calc u_next_pc_calc (
    .current_pc    (pc_r),
    .sign_ext_imm  (SignExtImm64),
    .branch        (Branch),
    .alu_zero      (ALUZero),
    .uncond_branch (Uncondbranch),
    .next_pc       (next_pc_s),
    .misaligned    (misaligned_s)
  );

  // Sequencer FSM; every output flag is registered alongside the state it belongs to.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_VECTOR;
      instr_r  <= {INSTR_W{1'b0}};
      retire_r <= {CNT_W{1'b0}};
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Halt) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ImemGnt) begin
            state_r <= ST_RESP;
            req_r   <= 1'b0;
          end else begin
            req_r <= 1'b1;
          end
        end
        // Data is only taken from the cycle after the grant, never alongside it.
        ST_RESP: begin
          if (ImemRespValid) begin
            instr_r <= ImemRdata;
            valid_r <= 1'b1;
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_RESP;
          end
        end
        ST_EXEC: begin
          if (ExecDone) begin
            if (misaligned_s) begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end else begin
              pc_r     <= next_pc_s;
              retire_r <= retire_r + {{(CNT_W-1){1'b0}}, 1'b1};
              if (Halt) begin
                state_r  <= ST_HALT;
                halted_r <= 1'b1;
              end else begin
                state_r <= ST_REQ;
                req_r   <= 1'b1;
              end
            end
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_HALT:  state_r <= ST_HALT;
        ST_FAULT: state_r <= ST_FAULT;
        // An illegal encoding parks the sequencer in FAULT with fetch disabled.
        default: begin
          state_r  <= ST_FAULT;
          req_r    <= 1'b0;
          halted_r <= 1'b0;
          fault_r  <= 1'b1;
        end
      endcase
    end
  end

  assign ImemReq     = req_r;
  assign ImemAddr    = pc_r;
  assign Instruction = instr_r;
  assign InstrValid  = valid_r;
  assign CurrentPC   = pc_r;
  assign Halted      = halted_r;
  assign Fault       = fault_r;
  assign RetireCount = retire_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a vector table for the main flow plus hand sequences.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRespValid;
  logic [31:0] ImemRdata;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        ExecDone;
  logic        Branch;
  logic        ALUZero;
  logic        Uncondbranch;
  logic [63:0] SignExtImm64;
  logic        Halt;
  logic [63:0] CurrentPC;
  logic        Halted;
  logic        Fault;
  logic [31:0] RetireCount;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_fault;

  localparam logic [63:0] NEG16 = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] NEG8  = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct {
    logic        gnt;
    logic        resp;
    logic [31:0] rdata;
    logic        done;
    logic        br;
    logic        zero;
    logic        unc;
    logic [63:0] imm;
    logic        e_req;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[32];
  int   n_vecs = 0;

  pc_fetch_sequencer dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .ImemGnt       (ImemGnt),
    .ImemRespValid (ImemRespValid),
    .ImemRdata     (ImemRdata),
    .Instruction   (Instruction),
    .InstrValid    (InstrValid),
    .ExecDone      (ExecDone),
    .Branch        (Branch),
    .ALUZero       (ALUZero),
    .Uncondbranch  (Uncondbranch),
    .SignExtImm64  (SignExtImm64),
    .Halt          (Halt),
    .CurrentPC     (CurrentPC),
    .Halted        (Halted),
    .Fault         (Fault),
    .RetireCount   (RetireCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ImemGnt       = 1'b0;
    ImemRespValid = 1'b0;
    ImemRdata     = 32'h0;
    ExecDone      = 1'b0;
    Branch        = 1'b0;
    ALUZero       = 1'b0;
    Uncondbranch  = 1'b0;
    SignExtImm64  = 64'h0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    clear_inputs();
    step();
    check_b("rst_req", ImemReq, 1'b0);
    check_b("rst_valid", InstrValid, 1'b0);
    check_w("rst_pc", CurrentPC, 64'h0);
    check_w("rst_instr", 64'(Instruction), 64'h0);
    check_w("rst_ret", 64'(RetireCount), 64'h0);
    check_b("rst_halted", Halted, 1'b0);
    check_b("rst_fault", Fault, 1'b0);
    step();
    Reset     = 1'b0;
    exp_pc    = 64'h0;
    exp_ret   = 32'd0;
    exp_fault = 1'b0;
  endtask

  task automatic add(input int gnt, input int resp, input logic [31:0] rdata, input int done,
                     input int br, input int zero, input int unc, input logic [63:0] imm,
                     input int e_req, input logic [63:0] e_pc, input int e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_ret);
    vecs[n_vecs].gnt     = (gnt != 0);
    vecs[n_vecs].resp    = (resp != 0);
    vecs[n_vecs].rdata   = rdata;
    vecs[n_vecs].done    = (done != 0);
    vecs[n_vecs].br      = (br != 0);
    vecs[n_vecs].zero    = (zero != 0);
    vecs[n_vecs].unc     = (unc != 0);
    vecs[n_vecs].imm     = imm;
    vecs[n_vecs].e_req   = (e_req != 0);
    vecs[n_vecs].e_pc    = e_pc;
    vecs[n_vecs].e_valid = (e_valid != 0);
    vecs[n_vecs].e_instr = e_instr;
    vecs[n_vecs].e_ret   = e_ret;
    n_vecs++;
  endtask

  // Starts in REQ; gw cycles without grant, rw cycles without response, then commits.
  task automatic run_instr(input int gw, input int rw, input logic [31:0] rd, input logic unc,
                           input logic br, input logic zero, input logic [63:0] imm);
    logic [63:0] nxt;
    logic        taken;
    for (int i = 0; i < gw; i++) begin
      check_b("stall_req", ImemReq, 1'b1);
      check_w("stall_addr", ImemAddr, exp_pc);
      step();
    end
    check_b("req", ImemReq, 1'b1);
    check_w("addr", ImemAddr, exp_pc);
    ImemGnt = 1'b1;
    step();
    ImemGnt = 1'b0;
    for (int i = 0; i < rw; i++) begin
      check_b("resp_wait_req", ImemReq, 1'b0);
      check_b("resp_wait_valid", InstrValid, 1'b0);
      step();
    end
    ImemRespValid = 1'b1;
    ImemRdata     = rd;
    step();
    ImemRespValid = 1'b0;
    ImemRdata     = 32'h0;
    check_b("exec_valid", InstrValid, 1'b1);
    check_w("exec_instr", 64'(Instruction), 64'(rd));
    ExecDone     = 1'b1;
    Uncondbranch = unc;
    Branch       = br;
    ALUZero      = zero;
    SignExtImm64 = imm;
    step();
    clear_inputs();
    taken = unc | (br & zero);
    nxt   = taken ? (exp_pc + imm) : (exp_pc + 64'd4);
    if (nxt[1:0] != 2'b00) begin
      exp_fault = 1'b1;
    end else begin
      exp_pc  = nxt;
      exp_ret = exp_ret + 32'd1;
    end
    check_b("valid_pulse_end", InstrValid, 1'b0);
    check_w("commit_pc", CurrentPC, exp_pc);
    check_w("commit_ret", 64'(RetireCount), 64'(exp_ret));
    check_b("commit_fault", Fault, exp_fault);
    check_b("commit_halted", Halted, Halt & ~exp_fault);
    check_b("commit_req", ImemReq, ~exp_fault & ~Halt);
  endtask

  initial begin
    Halt = 1'b0;
    clear_inputs();

    // gnt rsp rdata          dn br z  u  imm            req pc         v  instr          ret
    add(0, 0, 32'h0,          0, 0, 0, 0, 64'h0,         0, 64'h00, 0, 32'h0,          32'd0);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h00, 0, 32'h0,          32'd0);
    add(0, 1, 32'h1111_1111,  0, 0, 0, 0, 64'h0,         0, 64'h00, 0, 32'h0,          32'd0);
    add(0, 0, 32'h0,          1, 0, 0, 0, 64'h0,         0, 64'h00, 1, 32'h1111_1111,  32'd0);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h04, 0, 32'h1111_1111,  32'd1);
    add(0, 1, 32'h2222_2222,  0, 0, 0, 0, 64'h0,         0, 64'h04, 0, 32'h1111_1111,  32'd1);
    add(0, 0, 32'h0,          1, 0, 0, 0, 64'h0,         0, 64'h04, 1, 32'h2222_2222,  32'd1);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h08, 0, 32'h2222_2222,  32'd2);
    add(0, 1, 32'h3333_3333,  0, 0, 0, 0, 64'h0,         0, 64'h08, 0, 32'h2222_2222,  32'd2);
    add(0, 0, 32'h0,          1, 0, 0, 0, 64'h0,         0, 64'h08, 1, 32'h3333_3333,  32'd2);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h0C, 0, 32'h3333_3333,  32'd3);
    add(0, 1, 32'h4444_4444,  0, 0, 0, 0, 64'h0,         0, 64'h0C, 0, 32'h3333_3333,  32'd3);
    add(0, 0, 32'h0,          1, 0, 0, 1, 64'h34,        0, 64'h0C, 1, 32'h4444_4444,  32'd3);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h40, 0, 32'h4444_4444,  32'd4);
    add(0, 1, 32'h5555_5555,  0, 0, 0, 0, 64'h0,         0, 64'h40, 0, 32'h4444_4444,  32'd4);
    add(0, 0, 32'h0,          1, 1, 1, 0, NEG16,         0, 64'h40, 1, 32'h5555_5555,  32'd4);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h30, 0, 32'h5555_5555,  32'd5);
    add(0, 1, 32'h6666_6666,  0, 0, 0, 0, 64'h0,         0, 64'h30, 0, 32'h5555_5555,  32'd5);
    add(0, 0, 32'h0,          1, 0, 0, 1, 64'h10,        0, 64'h30, 1, 32'h6666_6666,  32'd5);
    add(1, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h40, 0, 32'h6666_6666,  32'd6);
    add(0, 1, 32'h7777_7777,  0, 0, 0, 0, 64'h0,         0, 64'h40, 0, 32'h6666_6666,  32'd6);
    add(0, 0, 32'h0,          0, 1, 1, 0, NEG16,         0, 64'h40, 1, 32'h7777_7777,  32'd6);
    add(0, 0, 32'h0,          1, 1, 0, 0, NEG16,         0, 64'h40, 0, 32'h7777_7777,  32'd6);
    add(0, 0, 32'h0,          1, 0, 0, 1, 64'h8,         1, 64'h44, 0, 32'h7777_7777,  32'd7);
    add(1, 1, 32'h9999_9999,  0, 0, 0, 0, 64'h0,         1, 64'h44, 0, 32'h7777_7777,  32'd7);
    add(0, 0, 32'h0,          0, 0, 0, 0, 64'h0,         0, 64'h44, 0, 32'h7777_7777,  32'd7);
    add(0, 1, 32'h8888_8888,  0, 0, 0, 0, 64'h0,         0, 64'h44, 0, 32'h7777_7777,  32'd7);
    add(0, 0, 32'h0,          1, 0, 0, 0, 64'h0,         0, 64'h44, 1, 32'h8888_8888,  32'd7);
    add(0, 0, 32'h0,          0, 0, 0, 0, 64'h0,         1, 64'h48, 0, 32'h8888_8888,  32'd8);

    do_reset();
    for (int i = 0; i < n_vecs; i++) begin
      ImemGnt       = vecs[i].gnt;
      ImemRespValid = vecs[i].resp;
      ImemRdata     = vecs[i].rdata;
      ExecDone      = vecs[i].done;
      Branch        = vecs[i].br;
      ALUZero       = vecs[i].zero;
      Uncondbranch  = vecs[i].unc;
      SignExtImm64  = vecs[i].imm;
      check_b($sformatf("v%0d_req", i), ImemReq, vecs[i].e_req);
      if (vecs[i].e_req) check_w($sformatf("v%0d_addr", i), ImemAddr, vecs[i].e_pc);
      check_b($sformatf("v%0d_valid", i), InstrValid, vecs[i].e_valid);
      check_w($sformatf("v%0d_instr", i), 64'(Instruction), 64'(vecs[i].e_instr));
      check_w($sformatf("v%0d_pc", i), CurrentPC, vecs[i].e_pc);
      check_w($sformatf("v%0d_ret", i), 64'(RetireCount), 64'(vecs[i].e_ret));
      check_b($sformatf("v%0d_halted", i), Halted, 1'b0);
      check_b($sformatf("v%0d_fault", i), Fault, 1'b0);
      step();
    end
    clear_inputs();

    // Grant stalled 5 cycles, response delayed 3, then PC wrap through the top of memory.
    do_reset();
    step();
    run_instr(5, 3, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 64'h0);
    run_instr(0, 0, 32'hA5A5_0002, 1'b1, 1'b0, 1'b0, NEG8);
    check_w("wrap_top_pc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(0, 0, 32'hA5A5_0003, 1'b0, 1'b0, 1'b0, 64'h0);
    check_w("wrap_zero_pc", CurrentPC, 64'h0);

    // Misaligned unconditional target from 0x10 faults and stops fetching.
    do_reset();
    step();
    run_instr(0, 0, 32'hB000_0001, 1'b1, 1'b0, 1'b0, 64'h10);
    run_instr(0, 0, 32'hB000_0002, 1'b1, 1'b0, 1'b0, 64'h6);
    ImemGnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_b("fault_hold", Fault, 1'b1);
      check_b("fault_noreq", ImemReq, 1'b0);
      check_w("fault_pc", CurrentPC, 64'h10);
      check_w("fault_ret", 64'(RetireCount), 64'd1);
    end
    ImemGnt = 1'b0;

    // Halt raised during REQ: the instruction still commits, then the sequencer parks.
    do_reset();
    step();
    Halt = 1'b1;
    run_instr(0, 0, 32'hC000_0001, 1'b0, 1'b0, 1'b0, 64'h0);
    ImemGnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_b("halt_hold", Halted, 1'b1);
      check_b("halt_noreq", ImemReq, 1'b0);
      check_w("halt_pc", CurrentPC, 64'h4);
    end
    ImemGnt = 1'b0;
    Reset = 1'b1;
    #1;
    check_w("halt_rst_pc", CurrentPC, 64'h0);
    check_b("halt_rst_halted", Halted, 1'b0);
    step();
    Reset = 1'b0;
    step();
    check_b("idle_halt", Halted, 1'b1);
    check_b("idle_halt_noreq", ImemReq, 1'b0);
    Halt = 1'b0;

    // Reset during RESP; a response arriving after release must be dropped.
    do_reset();
    step();
    ImemGnt = 1'b1;
    step();
    ImemGnt = 1'b0;
    check_b("resp_state_req", ImemReq, 1'b0);
    Reset = 1'b1;
    #1;
    check_w("async_rst_pc", CurrentPC, 64'h0);
    step();
    Reset         = 1'b0;
    ImemRespValid = 1'b1;
    ImemRdata     = 32'hDEAD_BEEF;
    step();
    ImemRespValid = 1'b0;
    ImemRdata     = 32'h0;
    check_b("late_resp_req", ImemReq, 1'b1);
    check_w("late_resp_addr", ImemAddr, 64'h0);
    check_b("late_resp_valid", InstrValid, 1'b0);
    check_w("late_resp_instr", 64'(Instruction), 64'h0);
    exp_pc    = 64'h0;
    exp_ret   = 32'd0;
    exp_fault = 1'b0;
    run_instr(1, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
